// File: rtl/siso_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : siso_reg_pkg
//  Description : Shared constants for the serial shift-register family.
//                Other single-bit serial blocks pull their default depth and
//                reset value from here so delay lines stay consistent.
//  Revision    : 1.0 - initial release
// ============================================================================
package siso_reg_pkg;

    // Default din-to-dout latency in clock edges.
    localparam int unsigned C_SISO_DEPTH_DEFAULT = 4;

    // Largest supported chain length.
    localparam int unsigned C_SISO_DEPTH_MAX     = 64;

    // Value every stage holds while reset is asserted.
    localparam logic        C_SISO_RESET_VAL     = 1'b0;

endpackage : siso_reg_pkg
`default_nettype wire

// File: rtl/siso_stage.sv
`default_nettype none
// ============================================================================
//  Module      : siso_stage
//  Description : One stage of the serial delay line: a D flip-flop with
//                asynchronous active-low reset to a programmable value.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                i_d   - data input
//                o_q   - registered data output
//  Revision    : 1.0 - initial release
// ============================================================================
module siso_stage #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : siso_stage
`default_nettype wire

// File: rtl/siso_reg.sv
`default_nettype none
// ============================================================================
//  Module      : siso_reg
//  Description : Serial-in serial-out shift register used as a fixed bit
//                delay line. A bit sampled on din at rising edge n appears on
//                dout right after edge n+DEPTH-1. Output is registered; there
//                is no combinational path from din to dout.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-low reset, clears every stage
//                din   - serial data in
//                dout  - serial data out (last stage)
//  Revision    : 1.0 - initial release
// ============================================================================
module siso_reg
    import siso_reg_pkg::*;
#(
    parameter int unsigned DEPTH     = C_SISO_DEPTH_DEFAULT,
    parameter logic        RESET_VAL = C_SISO_RESET_VAL
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    // Output of each stage; bit DEPTH-1 is the tail of the chain.
    logic [DEPTH-1:0] w_stage_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // Head stage captures the serial input directly.
                siso_stage #(
                    .RESET_VAL (RESET_VAL)
                ) u_stage (
                    .clk   (clk),
                    .rst_n (reset),
                    .i_d   (din),
                    .o_q   (w_stage_q[gi])
                );
            end else begin : g_body
                siso_stage #(
                    .RESET_VAL (RESET_VAL)
                ) u_stage (
                    .clk   (clk),
                    .rst_n (reset),
                    .i_d   (w_stage_q[gi-1]),
                    .o_q   (w_stage_q[gi])
                );
            end
        end
    endgenerate

    assign dout = w_stage_q[DEPTH-1];

endmodule : siso_reg
`default_nettype wire

// File: tb/tb_siso_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_siso_reg
//  Description : Self-checking bench for siso_reg at DEPTH = 4, 1 and 8.
//                Each driven bit is pushed into a per-instance expected queue
//                that is preloaded with DEPTH-1 reset values, so popping one
//                entry per clock edge yields the bit dout must show.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_siso_reg;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic din4  = 1'b0;
    logic din1  = 1'b0;
    logic din8  = 1'b0;
    logic dout4;
    logic dout1;
    logic dout8;

    int n_checks = 0;
    int n_pass   = 0;

    logic q4[$];
    logic q1[$];
    logic q8[$];

    always #5 clk = ~clk;

    siso_reg #(.DEPTH(4), .RESET_VAL(1'b0)) u_dut4 (
        .clk (clk), .reset (reset), .din (din4), .dout (dout4)
    );
    siso_reg #(.DEPTH(1), .RESET_VAL(1'b0)) u_dut1 (
        .clk (clk), .reset (reset), .din (din1), .dout (dout1)
    );
    siso_reg #(.DEPTH(8), .RESET_VAL(1'b0)) u_dut8 (
        .clk (clk), .reset (reset), .din (din8), .dout (dout8)
    );

    // After reset every chain holds zeros: the first DEPTH-1 edges emit them.
    task automatic sb_clear();
        q4.delete();
        q1.delete();
        q8.delete();
        for (int i = 0; i < 3; i++) q4.push_back(1'b0);
        for (int i = 0; i < 7; i++) q8.push_back(1'b0);
    endtask

    // Drive one bit per instance, record it, then advance past the edge.
    task automatic clock_in(input logic d4, input logic d1, input logic d8);
        din4 = d4;
        din1 = d1;
        din8 = d8;
        q4.push_back(d4);
        q1.push_back(d1);
        q8.push_back(d8);
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(output logic e4, output logic e1, output logic e8);
        e4 = q4.pop_front();
        e1 = q1.pop_front();
        e8 = q8.pop_front();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        din4  = 1'b1;
        din1  = 1'b1;
        din8  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({dout4, dout1, dout8} !== 3'b000)
                $display("FAIL reset_hold cycle %0d: dout4/1/8=%b%b%b expected 000",
                         k, dout4, dout1, dout8);
            else n_pass++;
        end
        reset = 1'b1;
        sb_clear();
    endtask

    task automatic test_latency();
        logic e4, e1, e8;
        for (int k = 1; k <= 6; k++) begin
            clock_in((k == 1), (k == 1), 1'b0);
            pop_exp(e4, e1, e8);
            n_checks++;
            if (dout4 !== e4)
                $display("FAIL latency4 edge %0d: dout=%b expected %b", k, dout4, e4);
            else n_pass++;
            n_checks++;
            if (dout1 !== e1)
                $display("FAIL latency1 edge %0d: dout=%b expected %b", k, dout1, e1);
            else n_pass++;
        end
    endtask

    task automatic test_pattern();
        logic [7:0] pat;
        logic e4, e1, e8;
        pat = 8'b1011_0010;
        for (int k = 0; k < 12; k++) begin
            if (k < 8) clock_in(pat[7-k], pat[7-k], pat[7-k]);
            else       clock_in(1'b0, 1'b0, 1'b0);
            pop_exp(e4, e1, e8);
            n_checks++;
            if (dout4 !== e4)
                $display("FAIL pattern4 edge %0d: dout=%b expected %b", k, dout4, e4);
            else n_pass++;
            n_checks++;
            if (dout8 !== e8)
                $display("FAIL pattern8 edge %0d: dout=%b expected %b", k, dout8, e8);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic e4, e1, e8;
        for (int k = 0; k < 4; k++) begin
            clock_in(1'b1, 1'b1, 1'b1);
            pop_exp(e4, e1, e8);
        end
        n_checks++;
        if (dout4 !== 1'b1)
            $display("FAIL async_preload: dout4=%b expected 1", dout4);
        else n_pass++;
        // Assert reset well between edges; outputs must clear with no clock.
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({dout4, dout1, dout8} !== 3'b000)
            $display("FAIL async_clear: dout4/1/8=%b%b%b expected 000", dout4, dout1, dout8);
        else n_pass++;
        #2;
        reset = 1'b1;
        sb_clear();
        for (int k = 0; k < 3; k++) begin
            clock_in(1'b0, 1'b0, 1'b0);
            pop_exp(e4, e1, e8);
            n_checks++;
            if (dout4 !== e4 || dout4 !== 1'b0)
                $display("FAIL async_after edge %0d: dout4=%b expected 0", k, dout4);
            else n_pass++;
        end
    endtask

    task automatic test_depth_sweep();
        logic [5:0] pat1;
        logic e4, e1, e8;
        pat1 = 6'b110100;
        for (int k = 0; k < 6; k++) begin
            clock_in(1'b0, pat1[5-k], 1'b0);
            pop_exp(e4, e1, e8);
            n_checks++;
            if (dout1 !== e1)
                $display("FAIL depth1 edge %0d: dout=%b expected %b", k, dout1, e1);
            else n_pass++;
        end
        // Flush anything still in the DEPTH=8 chain before the pulse.
        for (int k = 0; k < 8; k++) begin
            clock_in(1'b0, 1'b0, 1'b0);
            pop_exp(e4, e1, e8);
        end
        for (int k = 1; k <= 10; k++) begin
            clock_in(1'b0, 1'b0, (k == 1));
            pop_exp(e4, e1, e8);
            n_checks++;
            if (dout8 !== e8)
                $display("FAIL depth8 edge %0d: dout=%b expected %b", k, dout8, e8);
            else n_pass++;
        end
    endtask

    task automatic test_continuous_ones();
        logic e4, e1, e8;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        sb_clear();
        for (int k = 1; k <= 7; k++) begin
            clock_in(1'b1, 1'b1, 1'b1);
            pop_exp(e4, e1, e8);
            n_checks++;
            if (dout4 !== e4)
                $display("FAIL ones4 edge %0d: dout=%b expected %b", k, dout4, e4);
            else n_pass++;
            n_checks++;
            if (dout8 !== e8)
                $display("FAIL ones8 edge %0d: dout=%b expected %b", k, dout8, e8);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_pattern();
        test_async_reset();
        test_depth_sweep();
        test_continuous_ones();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_siso_reg
`default_nettype wire
